// File: rtl/top_level.sv
// Program #2 decryption engine: recovers LFSR seed and taps from a space preamble.
// Optional PARITY_CHECK_EN: marks bad-parity bytes 8'h80 and logs an error count to Core[255].

module data_mem (
    input  logic       clk_i,
    input  logic [7:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    input  logic       we_i,
    input  logic [7:0] wr_addr_i,
    input  logic [7:0] wr_data_i
`ifdef PARITY_CHECK_EN
    ,
    input  logic       stat_we_i,
    input  logic [7:0] stat_data_i
`endif
);
    logic [7:0] Core [0:255];

    assign rd_data_o = Core[rd_addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) Core[wr_addr_i] <= wr_data_i;
`ifdef PARITY_CHECK_EN
        if (stat_we_i) Core[8'hFF] <= stat_data_i;
`endif
    end
endmodule

module top_level (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);
    typedef enum logic [2:0] {
        IDLE, ARMED, LOAD, SEARCH, DECRYPT, DONE
    } state_t;

    function automatic logic [6:0] lfsr_step(input logic [6:0] s,
                                             input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    function automatic logic [6:0] ptrn_of(input logic [3:0] j);
        case (j)
            4'd0:    return 7'h60;
            4'd1:    return 7'h48;
            4'd2:    return 7'h78;
            4'd3:    return 7'h72;
            4'd4:    return 7'h6A;
            4'd5:    return 7'h69;
            4'd6:    return 7'h5C;
            4'd7:    return 7'h7E;
            4'd8:    return 7'h7B;
            default: return 7'h60;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [6:0] s_q, s_d;
    logic [6:0] p_q, p_d;
    logic [6:0] r_q [0:9];
    logic [6:0] r_d [0:9];

    logic [7:0] rd_data, wr_data;
    logic       we;
    logic [6:0] plain, cand, walk;
    logic       hit;
`ifdef PARITY_CHECK_EN
    logic [7:0] err_q, err_d;
    logic       stat_we;
`else
    logic       unused_bit7;
    assign unused_bit7 = rd_data[7];
`endif

    data_mem DM1 (
        .clk_i      (Clk),
        .rd_addr_i  ({2'b01, cnt_q}),
        .rd_data_o  (rd_data),
        .we_i       (we),
        .wr_addr_i  ({2'b00, cnt_q}),
        .wr_data_i  (wr_data)
`ifdef PARITY_CHECK_EN
        ,
        .stat_we_i  (stat_we),
        .stat_data_i(err_d)
`endif
    );

    // Candidate j must reproduce preamble states r[1..9] from seed r[0].
    always_comb begin
        cand = ptrn_of(cnt_q[3:0]);
        walk = r_q[0];
        hit  = 1'b1;
        for (int k = 1; k < 10; k++) begin
            walk = lfsr_step(walk, cand);
            if (walk != r_q[k]) hit = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        p_d     = p_q;
        r_d     = r_q;
        we      = 1'b0;
        plain   = rd_data[6:0] ^ s_q;
        wr_data = {1'b0, plain} + 8'h20;
`ifdef PARITY_CHECK_EN
        err_d   = err_q;
        stat_we = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (Start) state_d = ARMED;
            end
            ARMED: begin
                if (!Start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
`ifdef PARITY_CHECK_EN
                    err_d   = '0;
`endif
                end
            end
            LOAD: begin
                for (int k = 0; k < 10; k++)
                    if (cnt_q == 6'(k)) r_d[k] = rd_data[6:0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd9) begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                end
            end
            SEARCH: begin
                cnt_d = cnt_q + 6'd1;
                if (hit || r_q[0] == '0 || cnt_q == 6'd8) begin
                    state_d = DECRYPT;
                    cnt_d   = '0;
                    s_d     = r_q[0];
                    p_d     = hit ? cand : ptrn_of(4'd0);
                end
            end
            DECRYPT: begin
                we = 1'b1;
`ifdef PARITY_CHECK_EN
                if (rd_data[7] != ^rd_data[6:0]) begin
                    wr_data = 8'h80;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
                stat_we = (cnt_q == 6'd63);
`endif
                s_d   = lfsr_step(s_q, p_q);
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = DONE;
            end
            DONE: begin
                if (Start) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            p_q     <= '0;
            for (int k = 0; k < 10; k++) r_q[k] <= '0;
`ifdef PARITY_CHECK_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            p_q     <= p_d;
            r_q     <= r_d;
`ifdef PARITY_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign Ack = (state_q == DONE);
endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level: directed messages encrypted here, checked on Ack.
// Honours PARITY_CHECK_EN when the design is built with it.

module tb_top_level;
    logic Clk = 1'b0;
    logic Reset;
    logic Start;
    logic Ack;

    top_level dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .Ack  (Ack)
    );

    always #5 Clk = ~Clk;

    localparam logic [6:0] TAPS [0:8] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };
    localparam string MSG = "Mr. Watson, come here. I want to see you.";

    typedef struct {
        int               id;
        int               lat;
        logic [63:0][7:0] exp;
        logic [7:0]       exp255;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] ptxt [64];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         done_cnt = 0;
    logic       ack_d = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: every Ack rising edge retires one scoreboard entry.
    always @(negedge Clk) begin
        if (Ack && !ack_d) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("run%0d_latency", mon_e.id),
                      cyc - t0, mon_e.lat);
                for (int i = 0; i < 64; i++)
                    check($sformatf("run%0d_byte%0d", mon_e.id, i),
                          int'(dut.DM1.Core[i]), int'(mon_e.exp[i]));
                check($sformatf("run%0d_core255", mon_e.id),
                      int'(dut.DM1.Core[255]), int'(mon_e.exp255));
            end
            done_cnt <= done_cnt + 1;
        end
        ack_d <= Ack;
    end

    task automatic fill_plain(input int pre, input string msg);
        for (int i = 0; i < 64; i++) ptxt[i] = 8'h20;
        for (int i = 0; i < msg.len(); i++)
            if (pre + i < 64) ptxt[pre + i] = msg[i];
    endtask

    task automatic encode(input logic [6:0] init, input int pat);
        logic [6:0] s, c, p;
        s = init;
        for (int i = 0; i < 64; i++) begin
            p = 7'(ptxt[i] - 8'h20);
            c = p ^ s;
            dut.DM1.Core[64 + i] = {^c, c};
            dut.DM1.Core[i] = 8'hEE;
            s = {s[5:0], ^(s & TAPS[pat])};
        end
    endtask

    task automatic start_pulse();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        check("ack_low_armed", int'(Ack), 0);
        Start = 1'b0;
        t0 = cyc + 1;
    endtask

    task automatic go(input int id, input int pat,
                      input logic [6:0] init, input bit flip);
        exp_t e;
        int   d0;
        int   k;
        encode(init, pat);
        if (flip) begin
            dut.DM1.Core[80]  = dut.DM1.Core[80] ^ 8'h80;
            dut.DM1.Core[100] = dut.DM1.Core[100] ^ 8'h80;
            ptxt[16] = 8'h80;
            ptxt[36] = 8'h80;
        end
        e.id  = id;
        e.lat = 75 + pat;
        for (int i = 0; i < 64; i++) e.exp[i] = ptxt[i];
`ifdef PARITY_CHECK_EN
        e.exp255 = flip ? 8'd2 : 8'd0;
`else
        e.exp255 = 8'h5A;
`endif
        sb.push_back(e);
        start_pulse();
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge Clk);
            k++;
        end
        if (done_cnt == d0) begin
            check($sformatf("run%0d_timeout", id), 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        for (int i = 128; i < 255; i++) dut.DM1.Core[i] = 8'(i ^ 8'h3C);
        dut.DM1.Core[255] = 8'h5A;
        repeat (3) @(negedge Clk);
        check("reset_ack", int'(Ack), 0);
        check("reset_state", int'(dut.state_q), 0);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        check("idle_hold_ack", int'(Ack), 0);

        fill_plain(12, "  01234546789abcdefghijklmnopqrstuvwxyz. ");
        go(1, 2, 7'h35, 1'b0);

        for (int j = 0; j < 9; j++) begin
            fill_plain(10, MSG);
            go(10 + j, j, 7'h01, 1'b0);
        end

        fill_plain(15, "Hi there, max ~ byte");
        ptxt[20] = 8'h9F;
        go(20, 5, 7'h7F, 1'b0);

        // Reset in the middle of DECRYPT: Core[0..18] written, rest untouched.
        fill_plain(10, MSG);
        encode(7'h01, 0);
        start_pulse();
        while (cyc < t0 + 30) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("midrun_reset_ack", int'(Ack), 0);
        check("midrun_reset_state", int'(dut.state_q), 0);
        check("partial_byte0", int'(dut.DM1.Core[0]), int'(ptxt[0]));
        check("partial_byte18", int'(dut.DM1.Core[18]), int'(ptxt[18]));
        check("partial_byte19", int'(dut.DM1.Core[19]), 8'hEE);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        check("post_reset_ack", int'(Ack), 0);
        check("post_reset_state", int'(dut.state_q), 0);
        go(30, 0, 7'h01, 1'b0);

`ifdef PARITY_CHECK_EN
        fill_plain(10, MSG);
        go(40, 3, 7'h01, 1'b1);
`endif

        check("ack_held_done", int'(Ack), 1);
        fill_plain(11, "Second message, new text!");
        go(50, 7, 7'h01, 1'b0);

        check("untouched_128", int'(dut.DM1.Core[128]), 128 ^ 8'h3C);
        check("untouched_200", int'(dut.DM1.Core[200]), 200 ^ 8'h3C);
        check("untouched_254", int'(dut.DM1.Core[254]), 254 ^ 8'h3C);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
